// File: rtl/ex_wb_stage_pkg.sv
// Shared CPU definitions for the execute-to-writeback slice.
//   - Branch-type encodings carried in ctrl_brtype.
//   - Default datapath and register-address widths.
//   - Squash controller state encoding.
package ex_wb_stage_pkg;

    localparam int unsigned DATA_W_DEF  = 32;
    localparam int unsigned RADDR_W_DEF = 6;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_Z    = 2'b01,
        BR_N    = 2'b10,
        BR_J    = 2'b11
    } brtype_e;

    typedef enum logic {
        ST_RUN,
        ST_SQUASH
    } squash_state_e;

endpackage

// File: rtl/ex_wb_stage_branch_squash_ctrl.sv
// Squash window controller: after a taken branch, kills the next
// SQUASH_DEPTH valid, unstalled slots.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   taken        a live branch resolves taken at this edge
//   in_valid     current slot holds a real instruction
//   in_stall     stage held; the window does not advance
//   in_flush     external flush; closes the window immediately
//   out_squash   high while the squash counter is non-zero
module branch_squash_ctrl
    import ex_wb_stage_pkg::*;
#(
    parameter int unsigned SQUASH_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic taken,
    input  logic in_valid,
    input  logic in_stall,
    input  logic in_flush,
    output logic out_squash
);

    squash_state_e state, state_n;
    logic [2:0]    cnt, cnt_n;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // taken is only ever asserted from RUN, since a slot inside the
    // window is never live.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_RUN: begin
                if (!in_flush && taken) begin
                    cnt_n   = 3'(SQUASH_DEPTH);
                    state_n = ST_SQUASH;
                end
            end
            ST_SQUASH: begin
                if (in_flush) begin
                    cnt_n   = '0;
                    state_n = ST_RUN;
                end else if (in_valid && !in_stall) begin
                    cnt_n = cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state_n = ST_RUN;
                    end
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = ST_RUN;
            end
        endcase
    end

    assign out_squash = (state == ST_SQUASH);

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: commits register-file writes, holds the
// architectural Z/N flags, resolves conditional branches and squashes
// younger slots after a taken branch.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid, in_result, in_zero, in_mem_data, in_rd, in_pc_target
//                              instruction slot from the ALU
//   ctrl_regwrite, ctrl_memtoreg, ctrl_setflags, ctrl_brtype
//                              control bits travelling with the slot
//   in_stall, in_flush         hold / kill the current slot
//   out_rf_we, out_rf_waddr, out_rf_wdata   register-file write port
//   out_pc_load, out_pc_target              PC redirect
//   out_flag_z, out_flag_n                  architectural flags
//   out_squash                              squash window active
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned RADDR_W      = RADDR_W_DEF,
    parameter int unsigned SQUASH_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_result,
    input  logic               in_zero,
    input  logic [DATA_W-1:0]  in_mem_data,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0]  in_pc_target,
    input  logic               ctrl_regwrite,
    input  logic               ctrl_memtoreg,
    input  logic               ctrl_setflags,
    input  logic [1:0]         ctrl_brtype,
    input  logic               in_stall,
    input  logic               in_flush,
    output logic               out_rf_we,
    output logic [RADDR_W-1:0] out_rf_waddr,
    output logic [DATA_W-1:0]  out_rf_wdata,
    output logic               out_pc_load,
    output logic [DATA_W-1:0]  out_pc_target,
    output logic               out_flag_z,
    output logic               out_flag_n,
    output logic               out_squash
);

    logic live;
    logic taken;

    assign live = in_valid && !in_stall && !in_flush && !out_squash;

    // Branch tests the flags as they stand before this edge, so a
    // set-flags-and-branch slot sees the previous instruction's flags.
    always_comb begin
        taken = 1'b0;
        if (live) begin
            case (ctrl_brtype)
                BR_J:    taken = 1'b1;
                BR_Z:    taken = out_flag_z;
                BR_N:    taken = out_flag_n;
                default: taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_rf_we     <= 1'b0;
            out_rf_waddr  <= '0;
            out_rf_wdata  <= '0;
            out_pc_load   <= 1'b0;
            out_pc_target <= '0;
            out_flag_z    <= 1'b0;
            out_flag_n    <= 1'b0;
        end else begin
            out_rf_we   <= live && ctrl_regwrite;
            out_pc_load <= taken;
            if (live) begin
                out_rf_waddr <= in_rd;
                out_rf_wdata <= ctrl_memtoreg ? in_mem_data : in_result;
            end
            if (live && ctrl_setflags) begin
                out_flag_z <= in_zero;
                out_flag_n <= in_result[DATA_W-1];
            end
            if (taken) begin
                out_pc_target <= in_pc_target;
            end
        end
    end

    branch_squash_ctrl #(
        .SQUASH_DEPTH (SQUASH_DEPTH)
    ) u_squash (
        .clk        (clk),
        .rst_n      (rst_n),
        .taken      (taken),
        .in_valid   (in_valid),
        .in_stall   (in_stall),
        .in_flush   (in_flush),
        .out_squash (out_squash)
    );

endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_zero;
    logic [31:0] in_mem_data;
    logic [5:0]  in_rd;
    logic [31:0] in_pc_target;
    logic        ctrl_regwrite;
    logic        ctrl_memtoreg;
    logic        ctrl_setflags;
    logic [1:0]  ctrl_brtype;
    logic        in_stall;
    logic        in_flush;
    logic        out_rf_we;
    logic [5:0]  out_rf_waddr;
    logic [31:0] out_rf_wdata;
    logic        out_pc_load;
    logic [31:0] out_pc_target;
    logic        out_flag_z;
    logic        out_flag_n;
    logic        out_squash;

    int checks = 0;
    int failures = 0;

    // reference model state
    bit          m_we, m_pcl, m_z, m_n;
    logic [5:0]  m_waddr;
    logic [31:0] m_wdata, m_tgt;
    int          m_cnt;

    always #5 clk = ~clk;

    ex_wb_stage #(
        .DATA_W       (32),
        .RADDR_W      (6),
        .SQUASH_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_result     (in_result),
        .in_zero       (in_zero),
        .in_mem_data   (in_mem_data),
        .in_rd         (in_rd),
        .in_pc_target  (in_pc_target),
        .ctrl_regwrite (ctrl_regwrite),
        .ctrl_memtoreg (ctrl_memtoreg),
        .ctrl_setflags (ctrl_setflags),
        .ctrl_brtype   (ctrl_brtype),
        .in_stall      (in_stall),
        .in_flush      (in_flush),
        .out_rf_we     (out_rf_we),
        .out_rf_waddr  (out_rf_waddr),
        .out_rf_wdata  (out_rf_wdata),
        .out_pc_load   (out_pc_load),
        .out_pc_target (out_pc_target),
        .out_flag_z    (out_flag_z),
        .out_flag_n    (out_flag_n),
        .out_squash    (out_squash)
    );

    logic [74:0] got;
    assign got = {out_rf_we, out_rf_waddr, out_rf_wdata, out_pc_load,
                  out_pc_target, out_flag_z, out_flag_n, out_squash};

    function automatic logic [74:0] model_vec();
        return {m_we, m_waddr, m_wdata, m_pcl, m_tgt, m_z, m_n, (m_cnt != 0)};
    endfunction

    task automatic idle();
        rst_n = 1'b1; in_valid = 1'b0; in_result = '0; in_zero = 1'b0;
        in_mem_data = '0; in_rd = '0; in_pc_target = '0;
        ctrl_regwrite = 1'b0; ctrl_memtoreg = 1'b0; ctrl_setflags = 1'b0;
        ctrl_brtype = 2'b00; in_stall = 1'b0; in_flush = 1'b0;
    endtask

    // Advances the model by one slot from the current inputs, then
    // clocks the DUT and waits past the edge.
    task automatic step();
        bit live, tk;
        if (!rst_n) begin
            m_we = 0; m_pcl = 0; m_z = 0; m_n = 0;
            m_waddr = '0; m_wdata = '0; m_tgt = '0; m_cnt = 0;
        end else begin
            live = in_valid && !in_stall && !in_flush && (m_cnt == 0);
            tk = live && (ctrl_brtype == 3 || (ctrl_brtype == 1 && m_z) ||
                          (ctrl_brtype == 2 && m_n));
            m_we = live && ctrl_regwrite;
            if (live) begin
                m_waddr = in_rd;
                m_wdata = ctrl_memtoreg ? in_mem_data : in_result;
            end
            if (live && ctrl_setflags) begin
                m_z = in_zero;
                m_n = ((in_result >> 31) & 1) != 0;
            end
            m_pcl = tk;
            if (tk) m_tgt = in_pc_target;
            if (in_flush) m_cnt = 0;
            else if (tk) m_cnt = DEPTH;
            else if (!in_stall && in_valid && m_cnt > 0) m_cnt = m_cnt - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; in_valid = 1'b1; ctrl_regwrite = 1'b1; ctrl_brtype = 2'b11;
        in_result = 32'h1234; in_pc_target = 32'h99;
        step();
        step();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", got);
        end
        idle();
    endtask

    task automatic test_write();
        idle();
        in_valid = 1; in_result = 32'd5; in_rd = 6'd3; ctrl_regwrite = 1;
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr, out_rf_wdata} !== {1'b1, 6'd3, 32'd5}) begin
            failures++;
            $display("FAIL add_write got we=%b a=%0d d=%h want we=1 a=3 d=5",
                     out_rf_we, out_rf_waddr, out_rf_wdata);
        end
        idle();
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr} !== {1'b0, 6'd3}) begin
            failures++;
            $display("FAIL write_single_pulse got we=%b a=%0d want we=0 a=3",
                     out_rf_we, out_rf_waddr);
        end
        in_valid = 1; ctrl_regwrite = 1; ctrl_memtoreg = 1; in_rd = 6'd7;
        in_result = 32'h1; in_mem_data = 32'hDEAD_BEEF;
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr, out_rf_wdata} !== {1'b1, 6'd7, 32'hDEAD_BEEF}) begin
            failures++;
            $display("FAIL load_write got d=%h want deadbeef", out_rf_wdata);
        end
        idle();
    endtask

    task automatic test_flags();
        idle();
        in_valid = 1; ctrl_setflags = 1; in_result = 32'h0; in_zero = 1;
        step();
        checks++;
        if ({out_flag_z, out_flag_n, out_rf_we} !== 3'b100) begin
            failures++;
            $display("FAIL flags_zero got z=%b n=%b we=%b want z=1 n=0 we=0",
                     out_flag_z, out_flag_n, out_rf_we);
        end
        in_result = 32'hFFFF_FFFE; in_zero = 0;
        step();
        checks++;
        if ({out_flag_z, out_flag_n} !== 2'b01) begin
            failures++;
            $display("FAIL flags_neg got z=%b n=%b want z=0 n=1", out_flag_z, out_flag_n);
        end
        ctrl_setflags = 0; in_result = 32'h0; in_zero = 1;
        step();
        checks++;
        if ({out_flag_z, out_flag_n} !== 2'b01) begin
            failures++;
            $display("FAIL flags_hold got z=%b n=%b want z=0 n=1", out_flag_z, out_flag_n);
        end
        idle();
    endtask

    task automatic test_branch_squash();
        idle();
        in_valid = 1; ctrl_setflags = 1; in_zero = 1; in_result = 32'h0;
        step();
        ctrl_setflags = 0; ctrl_brtype = 2'b01; in_pc_target = 32'h40;
        step();
        checks++;
        if ({out_pc_load, out_pc_target, out_squash} !== {1'b1, 32'h40, 1'b1}) begin
            failures++;
            $display("FAIL brz_taken got pcl=%b t=%h sq=%b want pcl=1 t=40 sq=1",
                     out_pc_load, out_pc_target, out_squash);
        end
        ctrl_brtype = 2'b00; ctrl_regwrite = 1; in_rd = 6'd9; in_result = 32'h11;
        step();
        checks++;
        if ({out_rf_we, out_pc_load, out_pc_target, out_squash} !== {2'b00, 32'h40, 1'b1}) begin
            failures++;
            $display("FAIL squash_slot1 got we=%b pcl=%b t=%h sq=%b want 0 0 40 1",
                     out_rf_we, out_pc_load, out_pc_target, out_squash);
        end
        in_valid = 0;
        step();
        checks++;
        if ({out_rf_we, out_squash} !== 2'b01) begin
            failures++;
            $display("FAIL squash_bubble got we=%b sq=%b want we=0 sq=1", out_rf_we, out_squash);
        end
        in_valid = 1;
        step();
        checks++;
        if ({out_rf_we, out_squash} !== 2'b00) begin
            failures++;
            $display("FAIL squash_slot2 got we=%b sq=%b want we=0 sq=0", out_rf_we, out_squash);
        end
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr, out_rf_wdata, out_squash} !== {1'b1, 6'd9, 32'h11, 1'b0}) begin
            failures++;
            $display("FAIL post_squash_write got we=%b a=%0d d=%h sq=%b want 1 9 11 0",
                     out_rf_we, out_rf_waddr, out_rf_wdata, out_squash);
        end
        idle();
    endtask

    task automatic test_stall();
        idle();
        in_valid = 1; ctrl_regwrite = 1; in_rd = 6'd12; in_result = 32'h77; in_stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({out_rf_we, out_pc_load} !== 2'b00) begin
                failures++;
                $display("FAIL stall_quiet cyc=%0d got we=%b pcl=%b want 0 0",
                         i, out_rf_we, out_pc_load);
            end
        end
        in_stall = 0;
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr, out_rf_wdata} !== {1'b1, 6'd12, 32'h77}) begin
            failures++;
            $display("FAIL stall_release got we=%b a=%0d d=%h want 1 12 77",
                     out_rf_we, out_rf_waddr, out_rf_wdata);
        end
        idle();
        step();
        checks++;
        if (out_rf_we !== 1'b0) begin
            failures++;
            $display("FAIL stall_once got we=%b want 0", out_rf_we);
        end
    endtask

    task automatic test_brn_old_flag_and_reset();
        idle();
        in_valid = 1; ctrl_setflags = 1; in_result = 32'h1; in_zero = 0;
        step();
        in_result = 32'h8000_0000; ctrl_brtype = 2'b10; in_pc_target = 32'h100;
        step();
        checks++;
        if ({out_pc_load, out_flag_n, out_squash} !== 3'b010) begin
            failures++;
            $display("FAIL brn_old_flag got pcl=%b n=%b sq=%b want 0 1 0",
                     out_pc_load, out_flag_n, out_squash);
        end
        ctrl_setflags = 0; in_pc_target = 32'h200;
        step();
        checks++;
        if ({out_pc_load, out_pc_target} !== {1'b1, 32'h200}) begin
            failures++;
            $display("FAIL brn_taken got pcl=%b t=%h want 1 200", out_pc_load, out_pc_target);
        end
        ctrl_brtype = 2'b00; ctrl_regwrite = 1;
        step();
        rst_n = 0;
        step();
        checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL reset_mid_squash got=%h want=0", got);
        end
        rst_n = 1; in_rd = 6'd5; in_result = 32'hABC;
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr, out_rf_wdata, out_squash} !== {1'b1, 6'd5, 32'hABC, 1'b0}) begin
            failures++;
            $display("FAIL after_reset_write got we=%b a=%0d d=%h sq=%b want 1 5 abc 0",
                     out_rf_we, out_rf_waddr, out_rf_wdata, out_squash);
        end
        idle();
    endtask

    task automatic test_flush_mid_squash();
        idle();
        in_valid = 1; ctrl_setflags = 1; in_result = 32'h8000_0000; in_zero = 1;
        step();
        ctrl_setflags = 0; ctrl_brtype = 2'b11; in_pc_target = 32'h300;
        step();
        ctrl_brtype = 2'b00; ctrl_regwrite = 1;
        step();
        checks++;
        if (out_squash !== 1'b1) begin
            failures++;
            $display("FAIL jump_window got sq=%b want 1", out_squash);
        end
        in_flush = 1;
        step();
        checks++;
        if ({out_rf_we, out_pc_load, out_squash, out_flag_z, out_flag_n, out_pc_target}
            !== {5'b00011, 32'h300}) begin
            failures++;
            $display("FAIL flush_mid_squash got we=%b pcl=%b sq=%b z=%b n=%b t=%h want 0 0 0 1 1 300",
                     out_rf_we, out_pc_load, out_squash, out_flag_z, out_flag_n, out_pc_target);
        end
        in_flush = 0; in_rd = 6'd6; in_result = 32'h55;
        step();
        checks++;
        if ({out_rf_we, out_rf_waddr, out_rf_wdata} !== {1'b1, 6'd6, 32'h55}) begin
            failures++;
            $display("FAIL after_flush_write got we=%b a=%0d d=%h want 1 6 55",
                     out_rf_we, out_rf_waddr, out_rf_wdata);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rst_n         = ($urandom % 50) != 0;
            in_flush      = ($urandom % 12) == 0;
            in_stall      = ($urandom % 5) == 0;
            in_valid      = ($urandom % 4) != 0;
            in_result     = ($urandom % 4 == 0) ? 32'h0 : $urandom;
            in_zero       = (in_result == 0);
            in_mem_data   = $urandom;
            in_rd         = 6'($urandom);
            in_pc_target  = $urandom;
            ctrl_regwrite = $urandom % 2;
            ctrl_memtoreg = $urandom % 2;
            ctrl_setflags = $urandom % 2;
            ctrl_brtype   = 2'($urandom);
            step();
            checks++;
            if (got !== model_vec()) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h want=%h", i, got, model_vec());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        test_reset();
        test_write();
        test_flags();
        test_branch_squash();
        test_stall();
        test_brn_old_flag_and_reset();
        test_flush_mid_squash();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
